// File: rtl/bcd_digit_scanner_if.sv
// Bus between the seven-segment display front end and bcd_digit_scanner.
//   bin_in  unsigned value to convert, sampled on an accepted load
//   load    conversion request, accepted when the scanner is not busy
//   busy    conversion in progress
//   ovf     last accepted value was above 9999
//   bcd     digit for the currently enabled position
//   anode   active-low one-hot digit enable, bit 0 = ones digit
// master: the requester (drives bin_in/load). slave: the scanner.
interface bcd_digit_scanner_if #(
   parameter int BIN_W = 14
);
   logic [BIN_W-1:0] bin_in;
   logic             load;
   logic             busy;
   logic             ovf;
   logic [3:0]       bcd;
   logic [3:0]       anode;

   modport master (
      output bin_in, load,
      input  busy, ovf, bcd, anode
   );

   modport slave (
      input  bin_in, load,
      output busy, ovf, bcd, anode
   );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Converts a 14-bit binary value to four BCD digits by serial shift-add-3
// (one bit per clock) and time-multiplexes the digits onto one 4-bit bus
// for the seven-segment decoder.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_digit_scanner_if.slave (bin_in, load, busy, ovf, bcd, anode)
// Parameters:
//   SCAN_DIV  clocks per digit slot (2..2^20)
//   BIN_W     binary input width, fixed at 14
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  keeps the anode of leading-zero digits 3..1 off
//
// state | meaning
// IDLE  | waiting for load; display register holds the last committed value
// CONV  | one adjust-and-shift step per clock, 14 steps
// DONE  | commit digits (or 9999 on overflow) to the display register
module bcd_digit_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int BIN_W    = 14
) (
   input logic               clk,
   input logic               rst_n,
   bcd_digit_scanner_if.slave bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = 16 + BIN_W;

   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sr_q, sr_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic            big_q, big_d;
   logic [15:0]     disp_q, disp_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      bcd_q, bcd_d;
   logic [3:0]      anode_q, anode_d;
`ifdef LEADING_ZERO_BLANK_EN
   logic [3:1]      blank_q, blank_d;
`endif

   logic            capture, shift, commit;
   logic [SW-1:0]   adj;
   logic [15:0]     commit_val;
   logic            wrap;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.load) state_d = ST_CONV;
         ST_CONV: if (bit_cnt_q == 4'd13) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      capture  = (state_q == ST_IDLE) && bus.load;
      shift    = (state_q == ST_CONV);
      commit   = (state_q == ST_DONE);
      bus.busy = (state_q != ST_IDLE);
   end

   // conversion datapath
   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      big_d     = big_q;
      adj       = sr_q;
      for (int i = 0; i < 4; i++) begin
         if (adj[BIN_W + 4*i +: 4] >= 4'd5)
            adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
      end
      if (capture) begin
         sr_d      = {16'b0, bus.bin_in};
         bit_cnt_d = 4'd0;
         big_d     = (bus.bin_in > BIN_W'(9999));
      end else if (shift) begin
         sr_d      = {adj[SW-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q + 4'd1;
      end
   end

   // commit and scan
   always_comb begin
      commit_val = big_q ? 16'h9999 : sr_q[SW-1:BIN_W];
      disp_d     = commit ? commit_val : disp_q;
      ovf_d      = commit ? big_q : ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
      blank_d    = blank_q;
      if (commit) begin
         blank_d[3] = (commit_val[15:12] == 4'd0);
         blank_d[2] = blank_d[3] && (commit_val[11:8] == 4'd0);
         blank_d[1] = blank_d[2] && (commit_val[7:4] == 4'd0);
      end
`endif
      wrap    = (presc_q == PW'(SCAN_DIV - 1));
      presc_d = wrap ? '0 : presc_q + PW'(1);
      idx_d   = wrap ? idx_q + 2'd1 : idx_q;
      // bcd samples the display as it stands before this edge's commit
      bcd_d   = disp_q[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      anode_d = ~(4'b0001 << idx_d) | {blank_q, 1'b0};
`else
      anode_d = ~(4'b0001 << idx_d);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q      <= '0;
         bit_cnt_q <= 4'd0;
         big_q     <= 1'b0;
         disp_q    <= 16'h0000;
         ovf_q     <= 1'b0;
         presc_q   <= '0;
         idx_q     <= 2'd0;
         bcd_q     <= 4'd0;
         anode_q   <= 4'b1110;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q   <= 3'b000;
`endif
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         big_q     <= big_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         bcd_q     <= bcd_d;
         anode_q   <= anode_d;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q   <= blank_d;
`endif
      end
   end

   assign bus.ovf   = ovf_q;
   assign bus.bcd   = bcd_q;
   assign bus.anode = anode_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner with SCAN_DIV=4. Expected digits
// come from decimal arithmetic on the loaded value.
module tb_bcd_digit_scanner;

   localparam int SCAN_DIV = 4;

   logic clk;
   logic rst_n;
   int   tests  = 0;
   int   errors = 0;

   bcd_digit_scanner_if bus ();

   bcd_digit_scanner #(.SCAN_DIV(SCAN_DIV), .BIN_W(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int digit_of(input int v, input int p);
      int d = v;
      for (int i = 0; i < p; i++) d = d / 10;
      return d % 10;
   endfunction

   function automatic bit blanked(input int v, input int p);
`ifdef LEADING_ZERO_BLANK_EN
      return (p == 3 && v < 1000) || (p == 2 && v < 100) || (p == 1 && v < 10);
`else
      return 1'b0;
`endif
   endfunction

   // waits for busy to drop; counts negedge samples that still saw busy=1
   task automatic wait_busy(output int cnt);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.busy) cnt++;
         else break;
      end
   endtask

   // observes one full refresh period and compares every slot
   task automatic read_display(input int v, input bit blank_ok);
      int          ev;
      logic [3:0]  got [4];
      bit          seen [4];
      int          nblank_smp;
      int          nbad;
      int          nb;
      int          p;
      ev = (v > 9999) ? 9999 : v;
      nblank_smp = 0;
      nbad = 0;
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         got[i]  = 4'hF;
         seen[i] = 1'b0;
      end
      for (int n = 0; n < 4 * SCAN_DIV; n++) begin
         @(negedge clk);
         p = -1;
         case (bus.anode)
            4'b1110: p = 0;
            4'b1101: p = 1;
            4'b1011: p = 2;
            4'b0111: p = 3;
            4'b1111: nblank_smp++;
            default: nbad++;
         endcase
         if (p >= 0) begin
            got[p]  = bus.bcd;
            seen[p] = 1'b1;
         end
      end
      check_eq($sformatf("anode_illegal v=%0d", v), nbad, 0);
      for (int i = 0; i < 4; i++) begin
         if (blank_ok && blanked(ev, i)) begin
            nb++;
            check_eq($sformatf("blank v=%0d d%0d", v, i), seen[i], 0);
         end else begin
            check_eq($sformatf("digit v=%0d d%0d", v, i), got[i], digit_of(ev, i));
         end
      end
      check_eq($sformatf("blank_slots v=%0d", v), nblank_smp, nb * SCAN_DIV);
   endtask

   task automatic do_load(input int v);
      int cnt;
      @(negedge clk);
      bus.bin_in = 14'(v);
      bus.load   = 1'b1;
      @(posedge clk);
      #1 bus.load = 1'b0;
      wait_busy(cnt);
      check_eq($sformatf("busy_len v=%0d", v), cnt, 15);
      check_eq($sformatf("ovf v=%0d", v), bus.ovf, (v > 9999) ? 1 : 0);
      read_display(v, 1'b1);
   endtask

   // load 5678, then pulse load at E+3 and E+14 (ignored) and optionally E+16
   task automatic pulse_test(input bit with16);
      int ones;
      int cnt;
      @(negedge clk);
      bus.bin_in = 14'd5678;
      bus.load   = 1'b1;
      @(posedge clk);
      #1 bus.load = 1'b0;
      bus.bin_in = 14'd1111;
      ones = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k <= 15 && bus.busy) ones++;
         if (k == 16) check_eq("pulse busy_fall", bus.busy, 0);
         bus.load = (k == 3) || (k == 14) || (k == 16 && with16);
      end
      check_eq("pulse busy_len", ones, 15);
      if (with16) begin
         @(posedge clk);
         #1 bus.load = 1'b0;
         @(negedge clk);
         check_eq("accept_e16", bus.busy, 1);
         wait_busy(cnt);
         check_eq("busy_len_e16", cnt, 14);
         read_display(1111, 1'b1);
      end else begin
         read_display(5678, 1'b1);
      end
   endtask

   initial begin
      int cnt;
      int bnd [10];
      int v;
      bnd = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};
      rst_n      = 1'b0;
      bus.bin_in = '0;
      bus.load   = 1'b0;
      #23;
      check_eq("rst anode", bus.anode, 4'b1110);
      check_eq("rst bcd", bus.bcd, 0);
      check_eq("rst busy", bus.busy, 0);
      check_eq("rst ovf", bus.ovf, 0);
      @(negedge clk) rst_n = 1'b1;

      // reset asserted mid-scan, then the slot sequence after release
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midscan rst anode", bus.anode, 4'b1110);
      check_eq("midscan rst bcd", bus.bcd, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         check_eq($sformatf("scan n=%0d", n), bus.anode, ~(4'b0001 << ((n / SCAN_DIV) % 4)) & 4'hF);
      end

      do_load(1234);
      do_load(16383);
      do_load(42);
      pulse_test(1'b0);
      pulse_test(1'b1);

      // reset at CONV clock 7 of a 9999 conversion
      @(negedge clk);
      bus.bin_in = 14'd9999;
      bus.load   = 1'b1;
      @(posedge clk);
      #1 bus.load = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("conv rst busy", bus.busy, 0);
      check_eq("conv rst anode", bus.anode, 4'b1110);
      check_eq("conv rst bcd", bus.bcd, 0);
      check_eq("conv rst ovf", bus.ovf, 0);
      @(negedge clk) rst_n = 1'b1;
      read_display(0, 1'b0);
      do_load(7);

      foreach (bnd[i]) do_load(bnd[i]);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 16383);
         else                           v = $urandom_range(0, 9999);
         do_load(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
